uart_tx_periph: RTL

APB slave UART transmitter on the MCU peripheral bus, attached to a spare PSEL/PRDATA/PREADY slot of the APB master. The CPU writes bytes into the TXDATA register. They are buffered in an internal TX FIFO and serialised onto a single tx pin as 8N1 frames at a programmable baud divisor. Status bits let firmware poll FIFO level and busy.

---
 rtl/uart_tx_periph.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: APB slave UART transmitter (8N1, optional even parity).
//
// Ports:
//   PCLK            single clock, all state on rising edge
//   PRESET          synchronous active-low reset
//   PADDR[31:0]     APB address, only [3:2] decoded
//   PWDATA[31:0]    APB write data
//   PWRITE          1 = write, 0 = read
//   PENABLE, PSEL   APB access phase / slave select
//   PRDATA[31:0]    registered read data, valid while PREADY=1, else 0
//   PREADY          one-cycle registered completion pulse
//   tx              serial line, idle high
//
// Registers: 0x0 CTRL, 0x4 STATUS, 0x8 TXDATA, 0xC BAUD_DIV.
// Build option: define UART_TX_PARITY_EN to add CTRL.PAR_EN and the PARITY state.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, waiting for TX_EN and a queued byte
// S_START  | start bit (0) for one bit time
// S_DATA   | 8 data bits, LSB first
// S_PARITY | even parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (1) for one bit time

module uart_tx_periph #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        tx
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [1:0]  A_CTRL   = 2'd0;
    localparam logic [1:0]  A_STATUS = 2'd1;
    localparam logic [1:0]  A_TXDATA = 2'd2;
    localparam logic [1:0]  A_BAUD   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t      r_state;
    logic        r_pready;
    logic [31:0] r_prdata;
    logic        r_tx_en;
`ifdef UART_TX_PARITY_EN
    logic        r_par_en;
    logic        r_parity;
`endif
    logic [15:0] r_baud_div;
    logic        r_ovf;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_idx;
    logic [15:0] r_bit_cnt;
    logic [15:0] r_div_lat;
    logic        r_tx;

    logic        w_access;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_busy;
    logic        w_bit_done;
    logic        w_load;
    logic [AW:0] w_level;
    logic [7:0]  w_level8;
    logic [7:0]  w_head;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Only the first PSEL&PENABLE cycle counts; the PREADY cycle is masked
    // so a master holding PENABLE through PREADY does not re-trigger.
    assign w_access   = PSEL & PENABLE & ~r_pready;
    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_level8   = 8'(w_level);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push     = w_access & PWRITE & (PADDR[3:2] == A_TXDATA) & ~w_full;
    assign w_busy     = (r_state != S_IDLE);
    assign w_bit_done = (r_bit_cnt == r_div_lat - 16'd1);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    // A new frame starts from IDLE, or directly at the end of STOP so
    // back-to-back frames carry no idle bit.
    assign w_load     = r_tx_en & ~w_empty &
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));
    assign w_unused   = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

    assign PREADY = r_pready;
    assign PRDATA = r_prdata;
    assign tx     = r_tx;

    always_comb begin
        w_rdata = 32'd0;
        case (PADDR[3:2])
            A_CTRL: begin
                w_rdata[0] = r_tx_en;
`ifdef UART_TX_PARITY_EN
                w_rdata[1] = r_par_en;
`endif
            end
            A_STATUS: w_rdata = {16'd0, w_level8, 4'd0, r_ovf, w_busy, w_full, w_empty};
            A_BAUD:   w_rdata = {16'd0, r_baud_div};
            default:  w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            r_pready   <= 1'b0;
            r_prdata   <= 32'd0;
            r_tx_en    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en   <= 1'b0;
`endif
            r_baud_div <= 16'(DEFAULT_DIV);
            r_ovf      <= 1'b0;
            r_wr_ptr   <= '0;
        end else begin
            r_pready <= w_access;
            r_prdata <= (w_access && !PWRITE) ? w_rdata : 32'd0;
            if (w_access && PWRITE) begin
                case (PADDR[3:2])
                    A_CTRL: begin
                        r_tx_en  <= PWDATA[0];
`ifdef UART_TX_PARITY_EN
                        r_par_en <= PWDATA[1];
`endif
                    end
                    A_STATUS: if (PWDATA[3]) r_ovf <= 1'b0;
                    A_TXDATA: begin
                        if (w_full) r_ovf    <= 1'b1;
                        else        r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    end
                    A_BAUD: r_baud_div <= (PWDATA[15:0] == 16'd0) ? 16'd1 : PWDATA[15:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= PWDATA[7:0];
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_rd_ptr  <= '0;
            r_shift   <= 8'd0;
            r_bit_idx <= 3'd0;
            r_bit_cnt <= 16'd0;
            r_div_lat <= 16'd1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_load) begin
            r_state   <= S_START;
            r_tx      <= 1'b0;
            r_shift   <= w_head;
            r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            r_div_lat <= r_baud_div;
            r_bit_cnt <= 16'd0;
            r_bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^w_head;
`endif
        end else begin
            case (r_state)
                S_IDLE: r_tx <= 1'b1;
                S_START: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= 16'd0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= 16'd0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_bit_cnt <= 16'd0;
                        r_state   <= S_STOP;
                        r_tx      <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        r_bit_cnt <= 16'd0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
